// File: rtl/rx_iq_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rx_iq_scheduler
// Description : Buffers spectrum and voice IQ samples in two 4-entry FIFOs.
//               On each fetch request it pops at most one pair per stream and
//               holds them as a stable frame until the bus interface finishes.
//               The overflow counters exist only when RX_IQ_OVF_CNT_EN is
//               defined. Otherwise both counters read 0 and OVF_CLR has no
//               effect.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_iq_scheduler (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [15:0] SPEC_I,        // two's complement
   input  logic [15:0] SPEC_Q,        // two's complement
   input  logic        SPEC_VALID,
   input  logic [15:0] VOICE_I,       // two's complement
   input  logic [15:0] VOICE_Q,       // two's complement
   input  logic        VOICE_VALID,
   input  logic        FETCH_REQ,
   input  logic        FETCH_DONE,
   output logic [15:0] OUT_SPEC_I,
   output logic [15:0] OUT_SPEC_Q,
   output logic [15:0] OUT_VOICE_I,
   output logic [15:0] OUT_VOICE_Q,
   output logic        OUT_VALID,
   output logic [1:0]  OUT_FRESH,
   output logic [7:0]  SPEC_OVF_CNT,
   output logic [7:0]  VOICE_OVF_CNT,
   input  logic        OVF_CLR
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_POP     = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   localparam logic [2:0] C_DEPTH = 3'd4;

   state_t      state_q, state_d;
   logic        w_pop;
   logic [31:0] w_wdata [2];
   logic [1:0]  w_wvld;
   logic [31:0] w_out   [2];
   logic [1:0]  w_fresh;
   logic [7:0]  w_ovf   [2];

   // Index 0 is the spectrum stream and index 1 is the voice stream.
   assign w_wdata[0] = {SPEC_I, SPEC_Q};
   assign w_wdata[1] = {VOICE_I, VOICE_Q};
   assign w_wvld     = {VOICE_VALID, SPEC_VALID};

   // State register. An asynchronous reset aborts any frame in progress.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state decode. A request is honoured only in IDLE and a done pulse
   // only in PRESENT, so there is no request queuing.
   always_comb begin
      state_d   = state_q;
      w_pop     = 1'b0;
      OUT_VALID = 1'b0;
      case (state_q)
         ST_IDLE:    if (FETCH_REQ) state_d = ST_POP;
         ST_POP: begin
            w_pop   = 1'b1;
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            OUT_VALID = 1'b1;
            if (FETCH_DONE) state_d = ST_IDLE;
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   for (genvar s = 0; s < 2; s++) begin : g_stream
      logic [31:0] mem_q [4];
      logic [1:0]  wr_q, wr_d, rd_q, rd_d;
      logic [2:0]  cnt_q, cnt_d;
      logic [31:0] out_q, out_d;
      logic        fresh_q, fresh_d;
      logic        w_pop_mem, w_bypass, w_push, w_drop;

      // A pop from an empty FIFO takes a sample written in the same cycle
      // straight to the output, so the FIFO stays empty. A pop from a full
      // FIFO frees a slot for the same-cycle write, so nothing is dropped.
      always_comb begin
         w_pop_mem = w_pop && (cnt_q != 3'd0);
         w_bypass  = w_pop && (cnt_q == 3'd0) && w_wvld[s];
         w_push    = w_wvld[s] && !w_bypass && ((cnt_q != C_DEPTH) || w_pop_mem);
         w_drop    = w_wvld[s] && !w_bypass && !w_push;
         wr_d      = w_push    ? wr_q + 2'd1 : wr_q;
         rd_d      = w_pop_mem ? rd_q + 2'd1 : rd_q;
         cnt_d     = cnt_q + {2'd0, w_push} - {2'd0, w_pop_mem};
         out_d     = out_q;
         fresh_d   = fresh_q;
         if (w_pop) begin
            fresh_d = w_pop_mem || w_bypass;
            if (w_pop_mem)     out_d = mem_q[rd_q];
            else if (w_bypass) out_d = w_wdata[s];
         end
      end

      // Sample storage needs no reset because the pointers decide what is
      // valid.
      always_ff @(posedge clk_in) begin
         if (w_push) mem_q[wr_q] <= w_wdata[s];
      end

      // Pointer, occupancy and frame-output registers.
      always_ff @(posedge clk_in or posedge reset_in) begin
         if (reset_in) begin
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
            cnt_q   <= 3'd0;
            out_q   <= 32'd0;
            fresh_q <= 1'b0;
         end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            fresh_q <= fresh_d;
         end
      end

      assign w_out[s]   = out_q;
      assign w_fresh[s] = fresh_q;

`ifdef RX_IQ_OVF_CNT_EN
      logic [7:0] ovf_q, ovf_d;

      // A clear takes priority over a drop in the same cycle. The count
      // saturates at 255.
      always_comb begin
         ovf_d = ovf_q;
         if (OVF_CLR)                      ovf_d = 8'd0;
         else if (w_drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
      end

      // Dropped-sample counter register.
      always_ff @(posedge clk_in or posedge reset_in) begin
         if (reset_in) ovf_q <= 8'd0;
         else          ovf_q <= ovf_d;
      end

      assign w_ovf[s] = ovf_q;
`else
      logic w_unused_drop;
      assign w_unused_drop = w_drop;
      assign w_ovf[s]      = 8'd0;
`endif
   end

`ifndef RX_IQ_OVF_CNT_EN
   logic w_unused_clr;
   assign w_unused_clr = OVF_CLR;
`endif

   assign OUT_SPEC_I    = w_out[0][31:16];
   assign OUT_SPEC_Q    = w_out[0][15:0];
   assign OUT_VOICE_I   = w_out[1][31:16];
   assign OUT_VOICE_Q   = w_out[1][15:0];
   assign OUT_FRESH     = w_fresh;
   assign SPEC_OVF_CNT  = w_ovf[0];
   assign VOICE_OVF_CNT = w_ovf[1];

endmodule
`default_nettype wire

// File: tb/tb_rx_iq_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_iq_scheduler
// Description : Directed self-checking bench for rx_iq_scheduler. Expected
//               counter values follow RX_IQ_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_iq_scheduler;

`ifdef RX_IQ_OVF_CNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        reset_in = 1'b1;
   logic [15:0] SPEC_I = '0, SPEC_Q = '0, VOICE_I = '0, VOICE_Q = '0;
   logic        SPEC_VALID = 1'b0, VOICE_VALID = 1'b0;
   logic        FETCH_REQ = 1'b0, FETCH_DONE = 1'b0, OVF_CLR = 1'b0;
   logic [15:0] OUT_SPEC_I, OUT_SPEC_Q, OUT_VOICE_I, OUT_VOICE_Q;
   logic        OUT_VALID;
   logic [1:0]  OUT_FRESH;
   logic [7:0]  SPEC_OVF_CNT, VOICE_OVF_CNT;

   int n_total = 0;
   int n_bad   = 0;

   rx_iq_scheduler dut (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .SPEC_I       (SPEC_I),
      .SPEC_Q       (SPEC_Q),
      .SPEC_VALID   (SPEC_VALID),
      .VOICE_I      (VOICE_I),
      .VOICE_Q      (VOICE_Q),
      .VOICE_VALID  (VOICE_VALID),
      .FETCH_REQ    (FETCH_REQ),
      .FETCH_DONE   (FETCH_DONE),
      .OUT_SPEC_I   (OUT_SPEC_I),
      .OUT_SPEC_Q   (OUT_SPEC_Q),
      .OUT_VOICE_I  (OUT_VOICE_I),
      .OUT_VOICE_Q  (OUT_VOICE_Q),
      .OUT_VALID    (OUT_VALID),
      .OUT_FRESH    (OUT_FRESH),
      .SPEC_OVF_CNT (SPEC_OVF_CNT),
      .VOICE_OVF_CNT(VOICE_OVF_CNT),
      .OVF_CLR      (OVF_CLR)
   );

   always #5 clk_in = ~clk_in;

   // Expected counter value: n when the counters are built in, otherwise 0.
   function automatic logic [31:0] ovf(input int n);
      return OVF_EN ? 32'(n) : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge. One-cycle strobes are
   // released here.
   task automatic cyc();
      @(posedge clk_in);
      #1;
      SPEC_VALID = 1'b0; VOICE_VALID = 1'b0;
      FETCH_REQ = 1'b0; FETCH_DONE = 1'b0; OVF_CLR = 1'b0;
   endtask

   task automatic push_spec(input logic [15:0] i, input logic [15:0] q);
      SPEC_I = i; SPEC_Q = q; SPEC_VALID = 1'b1; cyc();
   endtask

   task automatic push_voice(input logic [15:0] i, input logic [15:0] q);
      VOICE_I = i; VOICE_Q = q; VOICE_VALID = 1'b1; cyc();
   endtask

   // Request a frame and check the two-cycle latency of OUT_VALID.
   task automatic start_frame(input string tag);
      FETCH_REQ = 1'b1; cyc();
      chk({tag, "_valid_pop"}, OUT_VALID, 1'b0);
      cyc();
      chk({tag, "_valid_present"}, OUT_VALID, 1'b1);
   endtask

   task automatic end_frame(input string tag);
      FETCH_DONE = 1'b1; cyc();
      chk({tag, "_valid_idle"}, OUT_VALID, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Samples strobed while reset is held must be discarded.
      SPEC_I = 16'h9999; SPEC_Q = 16'h8888; SPEC_VALID = 1'b1; VOICE_VALID = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_valid", OUT_VALID, 1'b0);
      chk("rst_fresh", OUT_FRESH, 2'b00);
      chk("rst_data", {OUT_SPEC_I, OUT_SPEC_Q}, 32'd0);
      chk("rst_vdata", {OUT_VOICE_I, OUT_VOICE_Q}, 32'd0);
      chk("rst_cnt", {SPEC_OVF_CNT, VOICE_OVF_CNT}, 32'd0);
      SPEC_VALID = 1'b0; VOICE_VALID = 1'b0; reset_in = 1'b0;
      cyc();

      // Nothing captured during reset: an empty frame is presented.
      start_frame("rstdisc");
      chk("rstdisc_fresh", OUT_FRESH, 2'b00);
      end_frame("rstdisc");

      // One spectrum sample followed by a fetch.
      push_spec(16'h1234, 16'hABCD);
      start_frame("basic");
      chk("basic_si", OUT_SPEC_I, 16'h1234);
      chk("basic_sq", OUT_SPEC_Q, 16'hABCD);
      chk("basic_fresh", OUT_FRESH, 2'b01);
      chk("basic_voice", {OUT_VOICE_I, OUT_VOICE_Q}, 32'd0);
      end_frame("basic");

      // Five voice samples overflow a 4-entry FIFO by one.
      for (int k = 1; k <= 5; k++) push_voice(16'(k), 16'(k + 16'h100));
      chk("v5_cnt", VOICE_OVF_CNT, ovf(1));
      chk("v5_scnt", SPEC_OVF_CNT, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         start_frame("v5");
         chk("v5_vi", OUT_VOICE_I, 32'(k));
         chk("v5_vq", OUT_VOICE_Q, 32'(k + 16'h100));
         chk("v5_fresh", OUT_FRESH, 2'b10);
         chk("v5_hold_si", OUT_SPEC_I, 16'h1234);
         end_frame("v5");
      end
      start_frame("v5e");
      chk("v5e_fresh", OUT_FRESH, 2'b00);
      chk("v5e_vi", OUT_VOICE_I, 16'd4);
      end_frame("v5e");

      // A repeated request during PRESENT is ignored and pops only once.
      push_spec(16'h00A1, 16'h00A2);
      push_spec(16'h00B1, 16'h00B2);
      start_frame("rq");
      chk("rq_si", OUT_SPEC_I, 16'h00A1);
      FETCH_REQ = 1'b1; cyc();
      chk("rq_still_valid", OUT_VALID, 1'b1);
      chk("rq_si_hold", OUT_SPEC_I, 16'h00A1);
      chk("rq_fresh_hold", OUT_FRESH, 2'b01);
      end_frame("rq");
      cyc(); cyc();
      chk("rq_no_queue", OUT_VALID, 1'b0);
      FETCH_DONE = 1'b1; cyc();        // done outside PRESENT: ignored
      chk("done_idle", OUT_VALID, 1'b0);
      start_frame("rq2");
      chk("rq2_si", OUT_SPEC_I, 16'h00B1);
      chk("rq2_fresh", OUT_FRESH, 2'b01);
      end_frame("rq2");
      start_frame("rq3");
      chk("rq3_fresh", OUT_FRESH, 2'b00);
      end_frame("rq3");

      // Full voice FIFO written during POP: no drop and still 4 entries.
      for (int k = 0; k < 4; k++) push_voice(16'(16'h10 + k), 16'h0);
      FETCH_REQ = 1'b1; cyc();
      VOICE_I = 16'h14; VOICE_Q = 16'h0; VOICE_VALID = 1'b1; cyc();
      chk("fullpop_valid", OUT_VALID, 1'b1);
      chk("fullpop_vi", OUT_VOICE_I, 16'h10);
      chk("fullpop_cnt", VOICE_OVF_CNT, ovf(1));
      end_frame("fullpop");
      for (int k = 1; k <= 4; k++) begin
         start_frame("fulldrain");
         chk("fulldrain_vi", OUT_VOICE_I, 32'(16'h10 + k));
         end_frame("fulldrain");
      end
      start_frame("fullempty");
      chk("fullempty_fresh", OUT_FRESH, 2'b00);
      end_frame("fullempty");

      // Empty voice FIFO written during POP: the sample bypasses the FIFO.
      FETCH_REQ = 1'b1; cyc();
      VOICE_I = 16'h55; VOICE_Q = 16'h66; VOICE_VALID = 1'b1; cyc();
      chk("byp_vi", OUT_VOICE_I, 16'h55);
      chk("byp_vq", OUT_VOICE_Q, 16'h66);
      chk("byp_fresh", OUT_FRESH, 2'b10);
      end_frame("byp");
      start_frame("byp2");
      chk("byp2_fresh", OUT_FRESH, 2'b00);
      end_frame("byp2");

      // 4 fills plus 300 drops saturate the spectrum counter.
      for (int k = 0; k < 304; k++) push_spec(16'(k), 16'(k + 1));
      chk("sat_scnt", SPEC_OVF_CNT, ovf(255));
      chk("sat_vcnt", VOICE_OVF_CNT, ovf(1));
      OVF_CLR = 1'b1; cyc();
      chk("clr_both", {SPEC_OVF_CNT, VOICE_OVF_CNT}, 32'd0);
      push_spec(16'hEEEE, 16'hEEEE);
      chk("drop_after_clr", SPEC_OVF_CNT, ovf(1));
      SPEC_VALID = 1'b1; OVF_CLR = 1'b1; cyc();
      chk("clr_vs_drop", SPEC_OVF_CNT, 32'd0);
      for (int k = 0; k < 4; k++) begin
         start_frame("satdrain");
         chk("satdrain_si", OUT_SPEC_I, 32'(k));
         chk("satdrain_sq", OUT_SPEC_Q, 32'(k + 1));
         end_frame("satdrain");
      end

      // Reset during PRESENT aborts the frame and empties the FIFOs.
      push_spec(16'h7777, 16'h7778);
      push_spec(16'h8881, 16'h8882);
      start_frame("rp");
      chk("rp_si", OUT_SPEC_I, 16'h7777);
      reset_in = 1'b1;
      #1;
      chk("rp_async_valid", OUT_VALID, 1'b0);
      chk("rp_async_data", {OUT_SPEC_I, OUT_SPEC_Q}, 32'd0);
      chk("rp_async_fresh", OUT_FRESH, 2'b00);
      #2 reset_in = 1'b0;
      cyc();
      FETCH_DONE = 1'b1; cyc();
      chk("rp_done_ign", OUT_VALID, 1'b0);
      cyc();
      chk("rp_no_frame", OUT_VALID, 1'b0);
      start_frame("rp2");
      chk("rp2_fresh", OUT_FRESH, 2'b00);
      chk("rp2_data", {OUT_SPEC_I, OUT_SPEC_Q}, 32'd0);
      end_frame("rp2");

      // Both streams strobed together are both accepted.
      SPEC_I = 16'h2222; SPEC_Q = 16'h3333; SPEC_VALID = 1'b1;
      VOICE_I = 16'h4444; VOICE_Q = 16'h5555; VOICE_VALID = 1'b1;
      cyc();
      start_frame("both");
      chk("both_s", {OUT_SPEC_I, OUT_SPEC_Q}, 32'h2222_3333);
      chk("both_v", {OUT_VOICE_I, OUT_VOICE_Q}, 32'h4444_5555);
      chk("both_fresh", OUT_FRESH, 2'b11);
      end_frame("both");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
